// File: rtl/alu_op_sequencer.sv
// Issuing master for the 4-bit alu: 3-cycle ALU ops, 2-cycle LDI, 4x4 register file.
// Optional macro ALU_SEQ_STICKY_V_EN makes v_flag accumulate overflow across ALU ops.
module alu_op_sequencer #(
   parameter int DATA_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              instr_valid,
   input  logic [13:0]       instr,
   output logic              instr_ready,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic [3:0]        alu_s,
   input  logic [DATA_W-1:0] alu_y,
   input  logic              alu_z,
   input  logic              alu_v,
   output logic              done,
   output logic              z_flag,
   output logic              v_flag,
   input  logic [1:0]        dbg_sel,
   output logic [DATA_W-1:0] dbg_data
);

   typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE} state_t;

   localparam logic [3:0] OP_LDI = 4'b1111;

   state_t            state;
   logic [DATA_W-1:0] rf [4];
   logic [3:0]        op_p0;
   logic [1:0]        rd_p0;
   logic [DATA_W-1:0] imm_p0;
   logic              accept;
   logic              v_next;

   assign instr_ready = (state == IDLE);
   assign accept      = instr_valid && instr_ready;
   assign dbg_data    = rf[dbg_sel];

`ifdef ALU_SEQ_STICKY_V_EN
   assign v_next = v_flag | alu_v;
`else
   assign v_next = alu_v;
`endif

   // Accept stage: the instruction is held here so the source need not keep it stable
   always_ff @(posedge clk) begin
      if (accept) begin
         op_p0  <= instr[13:10];
         rd_p0  <= instr[9:8];
         imm_p0 <= DATA_W'(instr[3:0]);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         rf     <= '{default: '0};
         alu_a  <= '0;
         alu_b  <= '0;
         alu_s  <= '0;
         done   <= 1'b0;
         z_flag <= 1'b0;
         v_flag <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (instr_valid) begin
                  state <= ISSUE;
                  // Operands read now, so rd may alias ra/rb and still see the old value
                  if (instr[13:10] != OP_LDI) begin
                     alu_a <= rf[instr[7:6]];
                     alu_b <= rf[instr[5:4]];
                     alu_s <= instr[13:10];
                  end
               end
            end
            ISSUE: begin
               if (op_p0 == OP_LDI) begin
                  rf[rd_p0] <= imm_p0;
                  done      <= 1'b1;
                  state     <= IDLE;
               end else begin
                  state <= CAPTURE;
               end
            end
            CAPTURE: begin
               rf[rd_p0] <= alu_y;
               z_flag    <= alu_z;
               v_flag    <= v_next;
               done      <= 1'b1;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Issuing master for the 4-bit `alu`. It accepts 14-bit instructions over a valid/ready handshake and keeps a 4-entry × 4-bit register file.
- For each instruction it drives the ALU operand and select lines from registers, then captures y/z/v a full cycle later. It writes the result back and updates the Z/V flags.
- It sits between a test or program source and an unmodified `alu` instance, turning the combinational ALU into a sequenced datapath.

Parameters:
- DATA_W, 4: datapath width. Must stay 4 because the `alu` slice is 4-bit.

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  synchronous, active-high reset
- instr_valid  input  1  instruction present on instr
- instr  input  14  [13:10]=op {s3,s2,s1,s0}, [9:8]=rd, [7:6]=ra, [5:4]=rb, [3:0]=imm
- instr_ready  output  1  sequencer can accept an instruction
- alu_a  output  4  to alu a3..a0 (bit i = ai)
- alu_b  output  4  to alu b3..b0 (bit i = bi)
- alu_s  output  4  to alu s3..s0 (bit i = si)
- alu_y  input  4  from alu y3..y0
- alu_z  input  1  from alu z
- alu_v  input  1  from alu v
- done  output  1  one-cycle pulse: instruction retired
- z_flag  output  1  registered zero flag
- v_flag  output  1  registered overflow flag
- dbg_sel  input  2  register-file read select
- dbg_data  output  4  combinational read of RF[dbg_sel]

Behaviour:
- Reset (synchronous, rst=1 at a rising edge):
  - state=IDLE; RF[0..3]=0; alu_a=alu_b=alu_s=0.
  - done=0; z_flag=0; v_flag=0.
  - instr_ready=1 from the first cycle after reset.
- FSM states: IDLE, ISSUE, CAPTURE. instr_ready=1 only in IDLE (decoded from state, not registered).
- Accept occurs at edge E0 when instr_valid & instr_ready. The whole instr is latched internally.
- ALU ops (op != 4'b1111):
  - E0: alu_a<=RF[ra], alu_b<=RF[rb], alu_s<=op; state->ISSUE.
  - E1: state->CAPTURE. The ALU has one full cycle to settle.
  - E2: RF[rd]<=alu_y, z_flag<=alu_z, v_flag<=alu_v, done<=1; state->IDLE.
  - done is high for exactly the cycle after E2. Throughput is one instruction per 3 cycles.
- ASR: any op with s3=1 except 4'b1111. It passes through unchanged; the `alu` ignores rb.
- LDI (op=4'b1111):
  - No ALU use; alu_a/b/s hold their previous values.
  - E0: state->ISSUE.
  - E1: RF[rd]<=imm, done<=1; state->IDLE.
  - Flags are unchanged. Latency is 2 cycles.
- Operands are sampled at E0, so ra==rd or rb==rd is legal and uses the pre-write value.
- A write at E2 is visible on dbg_data and to the next accepted instruction. There is no forwarding hazard because issue is serialized.
- instr_valid while not in IDLE is ignored. instr is not required to be held.
- rst during ISSUE or CAPTURE aborts the instruction:
  - no RF or flag write, and no done pulse;
  - full reset values apply at that edge.
- rst and instr_valid in the same cycle: reset wins and no accept occurs.
- done is deasserted in every cycle other than the retire cycle.

Optional Feature:
- Macro ALU_SEQ_STICKY_V_EN.
- Defined: on ALU retire, v_flag<=v_flag|alu_v. The flag is cleared only by rst. LDI never touches it.
- Undefined: v_flag<=alu_v on each ALU retire, so it reflects only the last ALU op.

Test Plan:
- Reset check: assert rst 2 cycles, release -> all RF=0, z_flag=0, v_flag=0, done=0, alu_s=0, instr_ready=1.
- LDI, stub ALU: op=1111, rd=2, imm=4'hA, accept at E0 -> instr_ready=0 for 1 cycle; done=1 in the cycle after E1; dbg_sel=2 gives 4'hA; flags unchanged.
- ALU timing, stub ALU: preload r1=3, r2=5. Issue op=0101, rd=0, ra=1, rb=2. Stub returns y=4'h9, z=0, v=1 -> alu_a=3, alu_b=5, alu_s=0101 from E0+1; RF[0]=9, v_flag=1, z_flag=0; done exactly in the cycle after E2.
- Back-to-back with real `alu`: LDI r0=0, LDI r1=4'hF, then op=0000 (AND) rd=3 ra=0 rb=1 with instr_valid held high throughout -> each accepted once; RF[3]=0, z_flag=1.
- Abort: accept an ALU op, assert rst in CAPTURE -> no done, RF[rd] stays 0, flags 0, state IDLE.
- Sticky V: first op with stub v=1, second op with stub v=0 -> v_flag=1 with ALU_SEQ_STICKY_V_EN, v_flag=0 without.
